// File: rtl/tim_etb_pkg.sv
// Shared definitions for the timer event-trigger router.
// Holds register offsets, source encodings, the channel FSM state type,
// the channel configuration / request structs and the channel count limit.
package tim_etb_pkg;

  localparam int NUM_CH_MAX = 4;

  localparam logic [7:0] OFF_CTRL    = 8'h00;
  localparam logic [7:0] OFF_CH0_CFG = 8'h04;
  localparam logic [7:0] OFF_STATUS  = 8'h14;
  localparam logic [7:0] OFF_SWTRIG  = 8'h18;

  localparam logic [1:0] SRC_TIM1 = 2'd0;
  localparam logic [1:0] SRC_TIM2 = 2'd1;
  localparam logic [1:0] SRC_EXT  = 2'd2;
  localparam logic [1:0] SRC_NONE = 2'd3;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ARMED,
    ST_FIRE,
    ST_DONE
  } ch_state_e;

  // Field order mirrors the CHn_CFG register layout: [3] act, [2] dst, [1:0] src.
  typedef struct packed {
    logic       act;
    logic       dst;
    logic [1:0] src;
  } ch_cfg_t;

  typedef struct packed {
    logic tim2_off;
    logic tim2_on;
    logic tim1_off;
    logic tim1_on;
  } trig_req_t;

  // Word index decoded from paddr[4:2].
  function automatic logic [2:0] reg_idx(input logic [7:0] off);
    return off[4:2];
  endfunction

endpackage

// File: rtl/tim_etb_route_if.sv
// APB slave bus of the event-trigger router.
// master: drives psel/penable/pwrite/paddr/pwdata, receives prdata.
// slave : the router side.
interface tim_etb_route_if;
  logic        psel;
  logic        penable;
  logic        pwrite;
  logic [31:0] paddr;
  logic [31:0] pwdata;
  logic [31:0] prdata;

  modport master (output psel, penable, pwrite, paddr, pwdata, input prdata);
  modport slave  (input psel, penable, pwrite, paddr, pwdata, output prdata);
endinterface

// File: rtl/tim_etb_chnl.sv
// One routing channel: source mux, channel FSM and the fire/request outputs.
// Ports:
//   clk, rst   - clock, async active-high reset
//   en_sw      - channel enable as it will be after this cycle's APB write
//   oneshot    - oneshot mode (current register value)
//   cfg        - src/dst/act configuration
//   hw_trig    - {ext, tim2, tim1} trigger pulses
//   sw_trig    - software trigger pulse (tied low when SWTRIG is not built)
//   fire       - high during the FIRE cycle
//   req        - decoded dst/act request, valid during FIRE
module tim_etb_chnl
  import tim_etb_pkg::*;
(
  input  logic      clk,
  input  logic      rst,
  input  logic      en_sw,
  input  logic      oneshot,
  input  ch_cfg_t   cfg,
  input  logic [2:0] hw_trig,
  input  logic      sw_trig,
  output logic      fire,
  output trig_req_t req
);

  ch_state_e st, st_nxt;
  logic      hw, trig;

  always_comb begin
    hw = 1'b0;
    case (cfg.src)
      SRC_TIM1: hw = hw_trig[0];
      SRC_TIM2: hw = hw_trig[1];
      SRC_EXT:  hw = hw_trig[2];
      default:  hw = 1'b0;
    endcase
  end

  assign trig = hw | sw_trig;

  always_ff @(posedge clk or posedge rst)
    if (rst) st <= ST_IDLE;
    else     st <= st_nxt;

  // en_sw is the post-write enable, so an en=1 write arms the channel
  // for the very next cycle and an en=0 write disarms it immediately.
  always_comb begin
    st_nxt = st;
    case (st)
      ST_IDLE, ST_DONE: if (en_sw) st_nxt = ST_ARMED;
      ST_ARMED: begin
        if (!en_sw)    st_nxt = ST_IDLE;
        else if (trig) st_nxt = ST_FIRE;
      end
      ST_FIRE: begin
        // a trigger seen during FIRE re-fires in continuous mode only
        if (oneshot)     st_nxt = ST_DONE;
        else if (!en_sw) st_nxt = ST_IDLE;
        else if (trig)   st_nxt = ST_FIRE;
        else             st_nxt = ST_ARMED;
      end
      default: st_nxt = ST_IDLE;
    endcase
  end

  assign fire         = (st == ST_FIRE);
  assign req.tim1_on  = fire & ~cfg.dst &  cfg.act;
  assign req.tim1_off = fire & ~cfg.dst & ~cfg.act;
  assign req.tim2_on  = fire &  cfg.dst &  cfg.act;
  assign req.tim2_off = fire &  cfg.dst & ~cfg.act;

endmodule

// File: rtl/tim_etb_route.sv
// Event-trigger router: routes timer/external trigger pulses through
// NUM_CH APB-configured channels onto the timer enable on/off pulse inputs.
// Ports:
//   pclk, preset        - APB clock, async active-high reset
//   apb                 - APB slave (CTRL, CHn_CFG, STATUS, SWTRIG)
//   tim1/tim2_etb_trig  - timer trigger pulses (sources 0/1)
//   ext_trig            - external trigger pulse (source 2)
//   etb_tim*_trig_en_*  - registered one-cycle request pulses
//   intr                - |(STATUS.fired & CTRL.ie)
// Build option: TIM_ETB_SWTRIG_EN adds the SWTRIG register at 0x18.
module tim_etb_route
  import tim_etb_pkg::*;
#(
  parameter int NUM_CH = 2
) (
  input  logic            pclk,
  input  logic            preset,
  tim_etb_route_if.slave  apb,
  input  logic            tim1_etb_trig,
  input  logic            tim2_etb_trig,
  input  logic            ext_trig,
  output logic            etb_tim1_trig_en_on,
  output logic            etb_tim1_trig_en_off,
  output logic            etb_tim2_trig_en_on,
  output logic            etb_tim2_trig_en_off,
  output logic            intr
);

  localparam logic [2:0] IDX_CTRL   = reg_idx(OFF_CTRL);
  localparam logic [2:0] IDX_CH0    = reg_idx(OFF_CH0_CFG);
  localparam logic [2:0] IDX_STATUS = reg_idx(OFF_STATUS);

  logic              wr, wr_ctrl, wr_stat;
  logic [2:0]        idx;
  logic [NUM_CH-1:0] en_q, os_q, ie_q, fired_q;
  logic [NUM_CH-1:0] en_sw, fire, sw_trig, w1c;
  ch_cfg_t           cfg_q [NUM_CH];
  trig_req_t         req   [NUM_CH];
  logic              on1, off1, on2, off2;
  logic [31:0]       rdata;
  logic              unused;

  assign wr      = apb.psel & apb.penable & apb.pwrite;
  assign idx     = apb.paddr[4:2];
  assign wr_ctrl = wr && (idx == IDX_CTRL);
  assign wr_stat = wr && (idx == IDX_STATUS);
  assign en_sw   = wr_ctrl ? apb.pwdata[NUM_CH-1:0] : en_q;
  assign w1c     = wr_stat ? apb.pwdata[NUM_CH-1:0] : '0;
  assign unused  = ^{apb.paddr, apb.pwdata};

`ifdef TIM_ETB_SWTRIG_EN
  localparam logic [2:0] IDX_SWTRIG = reg_idx(OFF_SWTRIG);
  assign sw_trig = (wr && (idx == IDX_SWTRIG)) ? apb.pwdata[NUM_CH-1:0] : '0;
`else
  assign sw_trig = '0;
`endif

  always_ff @(posedge pclk or posedge preset) begin
    if (preset) begin
      en_q    <= '0;
      os_q    <= '0;
      ie_q    <= '0;
      fired_q <= '0;
      for (int i = 0; i < NUM_CH; i++) cfg_q[i] <= '0;
    end else begin
      if (wr_ctrl) begin
        os_q <= apb.pwdata[8 +: NUM_CH];
        ie_q <= apb.pwdata[16 +: NUM_CH];
      end
      // a oneshot fire clears its enable, overriding a same-cycle write
      en_q    <= en_sw & ~(fire & os_q);
      // set from FIRE wins over a simultaneous W1C
      fired_q <= (fired_q & ~w1c) | fire;
      for (int i = 0; i < NUM_CH; i++)
        if (wr && (idx == IDX_CH0 + 3'(i))) cfg_q[i] <= ch_cfg_t'(apb.pwdata[3:0]);
    end
  end

  for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
    tim_etb_chnl u_ch (
      .clk     (pclk),
      .rst     (preset),
      .en_sw   (en_sw[g]),
      .oneshot (os_q[g]),
      .cfg     (cfg_q[g]),
      .hw_trig ({ext_trig, tim2_etb_trig, tim1_etb_trig}),
      .sw_trig (sw_trig[g]),
      .fire    (fire[g]),
      .req     (req[g])
    );
  end

  always_comb begin
    on1 = 1'b0; off1 = 1'b0; on2 = 1'b0; off2 = 1'b0;
    for (int i = 0; i < NUM_CH; i++) begin
      on1  = on1  | req[i].tim1_on;
      off1 = off1 | req[i].tim1_off;
      on2  = on2  | req[i].tim2_on;
      off2 = off2 | req[i].tim2_off;
    end
  end

  // off beats on for the same timer
  always_ff @(posedge pclk or posedge preset) begin
    if (preset) begin
      etb_tim1_trig_en_on  <= 1'b0;
      etb_tim1_trig_en_off <= 1'b0;
      etb_tim2_trig_en_on  <= 1'b0;
      etb_tim2_trig_en_off <= 1'b0;
    end else begin
      etb_tim1_trig_en_on  <= on1 & ~off1;
      etb_tim1_trig_en_off <= off1;
      etb_tim2_trig_en_on  <= on2 & ~off2;
      etb_tim2_trig_en_off <= off2;
    end
  end

  assign intr = |(fired_q & ie_q);

  always_comb begin
    rdata = '0;
    if (apb.psel && !apb.pwrite) begin
      if (idx == IDX_CTRL) begin
        rdata[NUM_CH-1:0]   = en_q;
        rdata[8 +: NUM_CH]  = os_q;
        rdata[16 +: NUM_CH] = ie_q;
      end else if (idx == IDX_STATUS) begin
        rdata[NUM_CH-1:0] = fired_q;
      end
      for (int i = 0; i < NUM_CH; i++)
        if (idx == IDX_CH0 + 3'(i)) rdata[3:0] = cfg_q[i];
    end
  end

  assign apb.prdata = rdata;

endmodule

// File: tb/tb_tim_etb_route.sv
module tb_tim_etb_route;
  import tim_etb_pkg::*;

  localparam int NUM_CH = 2;

  logic pclk = 1'b0, preset = 1'b1;
  logic tim1_etb_trig = 1'b0, tim2_etb_trig = 1'b0, ext_trig = 1'b0;
  logic t1on, t1off, t2on, t2off, intr;

  tim_etb_route_if bus ();

  tim_etb_route #(.NUM_CH(NUM_CH)) dut (
    .pclk                 (pclk),
    .preset               (preset),
    .apb                  (bus),
    .tim1_etb_trig        (tim1_etb_trig),
    .tim2_etb_trig        (tim2_etb_trig),
    .ext_trig             (ext_trig),
    .etb_tim1_trig_en_on  (t1on),
    .etb_tim1_trig_en_off (t1off),
    .etb_tim2_trig_en_on  (t2on),
    .etb_tim2_trig_en_off (t2off),
    .intr                 (intr)
  );

  always #5 pclk = ~pclk;

  int n_chk = 0, n_pass = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
  endtask

  function automatic logic [3:0] outs();
    return {t2off, t2on, t1off, t1on};
  endfunction

  task automatic step();
    @(posedge pclk); #1;
  endtask

  task automatic bus_idle();
    bus.psel = 1'b0; bus.penable = 1'b0; bus.pwrite = 1'b0;
    bus.paddr = '0;  bus.pwdata = '0;
  endtask

  task automatic bus_wr_drive(input logic [31:0] a, input logic [31:0] d);
    bus.psel = 1'b1; bus.penable = 1'b1; bus.pwrite = 1'b1;
    bus.paddr = a;   bus.pwdata = d;
  endtask

  task automatic wr(input logic [31:0] a, input logic [31:0] d);
    bus_wr_drive(a, d);
    step();
    bus_idle();
  endtask

  task automatic rd(input logic [31:0] a, output logic [31:0] d);
    bus.psel = 1'b1; bus.penable = 1'b1; bus.pwrite = 1'b0; bus.paddr = a;
    #1;
    d = bus.prdata;
    bus_idle();
  endtask

  task automatic set_trig(input logic [2:0] v);
    {ext_trig, tim2_etb_trig, tim1_etb_trig} = v;
  endtask

  task automatic do_reset();
    preset = 1'b1; set_trig(3'b000); bus_idle();
    step(); step();
    preset = 1'b0;
  endtask

  // ---------------- reference model (channel behaviour from the rules) ----
  logic [NUM_CH-1:0] m_en, m_os, m_ie, m_fired, m_firing;
  logic [3:0]        m_cfg [NUM_CH];
  logic [3:0]        m_out;

  task automatic m_init();
    m_en = '0; m_os = '0; m_ie = '0; m_fired = '0; m_firing = '0; m_out = '0;
    for (int i = 0; i < NUM_CH; i++) m_cfg[i] = '0;
  endtask

  function automatic logic m_intr();
    return |(m_fired & m_ie);
  endfunction

  function automatic logic [31:0] m_read(input int ridx);
    logic [31:0] r;
    r = '0;
    if (ridx == 0) begin
      for (int i = 0; i < NUM_CH; i++) begin
        r[i] = m_en[i]; r[8+i] = m_os[i]; r[16+i] = m_ie[i];
      end
    end else if (ridx == 5) r = 32'(m_fired);
    else if (ridx >= 1 && ridx <= NUM_CH) r = 32'(m_cfg[ridx-1]);
    return r;
  endfunction

  // A channel is able to detect while it is enabled; a detected trigger
  // fires it the next cycle; the registered output follows one cycle later.
  task automatic m_update(input logic [2:0] trig, input logic w, input int widx,
                          input logic [31:0] wd);
    logic on1, off1, on2, off2;
    logic [NUM_CH-1:0] sw, en_n, fire_n, wv;
    logic hw;
    int src;
    on1 = 0; off1 = 0; on2 = 0; off2 = 0;
    for (int i = 0; i < NUM_CH; i++) if (m_firing[i]) begin
      if (m_cfg[i][2] == 0) begin if (m_cfg[i][3]) on1 = 1; else off1 = 1; end
      else                  begin if (m_cfg[i][3]) on2 = 1; else off2 = 1; end
    end
    sw = '0;
`ifdef TIM_ETB_SWTRIG_EN
    if (w && widx == 6) sw = wd[NUM_CH-1:0];
`endif
    wv = wd[NUM_CH-1:0];
    for (int i = 0; i < NUM_CH; i++) begin
      en_n[i] = (w && widx == 0) ? wv[i] : m_en[i];
      src = int'(m_cfg[i][1:0]);
      hw  = (src == 3) ? 1'b0 : trig[src];
      fire_n[i] = m_en[i] && en_n[i] && (hw || sw[i]) && !(m_firing[i] && m_os[i]);
      if (m_firing[i] && m_os[i]) en_n[i] = 1'b0;
    end
    m_out   = {off2, on2 & ~off2, off1, on1 & ~off1};
    m_fired = (m_fired & ~((w && widx == 5) ? wv : '0)) | m_firing;
    if (w && widx == 0) begin
      m_os = wd[8 +: NUM_CH]; m_ie = wd[16 +: NUM_CH];
    end
    if (w && widx >= 1 && widx <= NUM_CH) m_cfg[widx-1] = wd[3:0];
    m_en     = en_n;
    m_firing = fire_n;
  endtask

  // ---------------- tables ----------------
  typedef struct { logic [3:0] cfg; logic [2:0] trig; logic [3:0] exp; } route_vec_t;
  typedef struct { logic [31:0] addr; logic [31:0] wdata; logic [31:0] exp; } reg_vec_t;
  route_vec_t rv [7];
  reg_vec_t   gv [10];

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    logic [31:0] d;
    logic [6:0]  pat, other;
    int cnt;

    rv[0] = '{4'h8, 3'b001, 4'b0001};
    rv[1] = '{4'hC, 3'b001, 4'b0100};
    rv[2] = '{4'h1, 3'b010, 4'b0010};
    rv[3] = '{4'h6, 3'b100, 4'b1000};
    rv[4] = '{4'hA, 3'b011, 4'b0000};
    rv[5] = '{4'hB, 3'b111, 4'b0000};
    rv[6] = '{4'hD, 3'b010, 4'b0100};

    gv[0] = '{32'h04, 32'hFFFF_FFFF, 32'h0000_000F};
    gv[1] = '{32'h08, 32'h0000_0005, 32'h0000_0005};
    gv[2] = '{32'h0C, 32'h0000_000F, 32'h0};
    gv[3] = '{32'h10, 32'h0000_000F, 32'h0};
    gv[4] = '{32'h1C, 32'h0000_FFFF, 32'h0};
    gv[5] = '{32'h00, 32'hFFFF_FFFF, 32'h0003_0303};
    gv[6] = '{32'h00, 32'h0000_0000, 32'h0};
    gv[7] = '{32'h14, 32'h0000_00FF, 32'h0};
    gv[8] = '{32'h18, 32'h0000_0000, 32'h0};
    gv[9] = '{32'h04, 32'h0000_0003, 32'h0000_0003};

    bus_idle();
    do_reset();

    // reset state
    chk("reset_outs", {27'd0, intr, outs()}, 32'h0);
    rd(32'h00, d); chk("reset_ctrl", d, 32'h0);
    rd(32'h04, d); chk("reset_cfg0", d, 32'h0);
    rd(32'h14, d); chk("reset_status", d, 32'h0);

    // register write/read-back table
    for (int i = 0; i < 10; i++) begin
      wr(gv[i].addr, gv[i].wdata);
      rd(gv[i].addr, d);
      chk($sformatf("reg[%0d]", i), d, gv[i].exp);
    end

    // routing table: pulse in N, nothing in N+1, pulse in N+2, nothing in N+3
    for (int i = 0; i < 7; i++) begin
      do_reset();
      wr(32'h04, 32'(rv[i].cfg));
      wr(32'h00, 32'h1);
      set_trig(rv[i].trig);
      step(); set_trig(3'b000);
      chk($sformatf("route[%0d]_n1", i), 32'(outs()), 32'h0);
      step();
      chk($sformatf("route[%0d]_n2", i), 32'(outs()), 32'(rv[i].exp));
      step();
      chk($sformatf("route[%0d]_n3", i), 32'(outs()), 32'h0);
    end

    // basic fire + STATUS
    do_reset();
    wr(32'h04, 32'hC); wr(32'h00, 32'h1);
    set_trig(3'b001); step(); set_trig(3'b000); step();
    chk("basic_pulse", 32'(outs()), 32'h4);
    step();
    chk("basic_after", 32'(outs()), 32'h0);
    rd(32'h14, d); chk("basic_status", d, 32'h1);

    // oneshot: two pulses 5 cycles apart -> one output pulse
    do_reset();
    wr(32'h04, 32'hC); wr(32'h00, 32'h101);
    cnt = 0;
    set_trig(3'b001); step(); set_trig(3'b000);
    for (int c = 0; c < 12; c++) begin
      if (c == 4) set_trig(3'b001);
      if (c == 5) set_trig(3'b000);
      if (outs() != 4'b0000) cnt++;
      step();
    end
    chk("oneshot_count", 32'(cnt), 32'd1);
    rd(32'h00, d); chk("oneshot_ctrl", d, 32'h100);

    // on and off for the same timer: off wins
    do_reset();
    wr(32'h04, 32'hA); wr(32'h08, 32'h2); wr(32'h00, 32'h3);
    set_trig(3'b100); step(); set_trig(3'b000); step();
    chk("off_priority", 32'(outs()), 32'h2);

    // continuous source high 3 cycles -> 3 pulses from N+2
    do_reset();
    wr(32'h04, 32'hC); wr(32'h00, 32'h1);
    pat = '0; other = '0;
    for (int c = 0; c < 7; c++) begin
      if (c == 0) set_trig(3'b001);
      if (c == 3) set_trig(3'b000);
      pat[c]   = t2on;
      other[c] = t1on | t1off | t2off;
      step();
    end
    chk("cont_pattern", 32'(pat), 32'h1C);
    chk("cont_other", 32'(other), 32'h0);

    // en=1 write in N: pulse in N ignored, pulse in N+1 detected
    do_reset();
    wr(32'h04, 32'hC);
    bus_wr_drive(32'h00, 32'h1); set_trig(3'b001);
    step(); bus_idle(); set_trig(3'b000);
    step();
    chk("en_same_cycle", 32'(outs()), 32'h0);
    wr(32'h00, 32'h0);
    bus_wr_drive(32'h00, 32'h1);
    step(); bus_idle(); set_trig(3'b001);
    step(); set_trig(3'b000);
    step();
    chk("en_next_cycle", 32'(outs()), 32'h4);

    // interrupt set and W1C clear
    do_reset();
    wr(32'h04, 32'hC); wr(32'h00, 32'h10001);
    chk("intr_idle", 32'(intr), 32'h0);
    set_trig(3'b001); step(); set_trig(3'b000); step();
    chk("intr_set", 32'(intr), 32'h1);
    wr(32'h14, 32'h1);
    chk("intr_clear", 32'(intr), 32'h0);

    // software trigger
    do_reset();
    wr(32'h08, 32'h3); wr(32'h00, 32'h2);
    set_trig(3'b111); step(); set_trig(3'b000); step();
    chk("src_none_hw", 32'(outs()), 32'h0);
    wr(32'h18, 32'h2);
    chk("swtrig_n1", 32'(outs()), 32'h0);
    step();
`ifdef TIM_ETB_SWTRIG_EN
    chk("swtrig_n2", 32'(outs()), 32'h2);
`else
    chk("swtrig_absent", 32'(outs()), 32'h0);
`endif
    rd(32'h18, d); chk("swtrig_read", d, 32'h0);

    // reset asserted while firing
    do_reset();
    wr(32'h04, 32'hC); wr(32'h00, 32'h10001);
    set_trig(3'b001); step(); step();
    chk("pre_reset_pulse", 32'(outs()), 32'h4);
    #2; preset = 1'b1; #1;
    chk("reset_async", {27'd0, intr, outs()}, 32'h0);
    step(); set_trig(3'b000); preset = 1'b0;
    rd(32'h00, d); chk("post_reset_ctrl", d, 32'h0);
    rd(32'h14, d); chk("post_reset_status", d, 32'h0);
    step(); step();
    chk("post_reset_outs", 32'(outs()), 32'h0);

    // randomized run against the reference model
    do_reset();
    m_init();
    for (int t = 0; t < 3000; t++) begin
      logic [2:0]  trig;
      logic        w;
      int          widx, op, ridx;
      logic [31:0] wd, rdat;
      step();
      chk("rnd_out", {27'd0, intr, outs()}, {27'd0, m_intr(), m_out});
      trig = {($urandom_range(0, 3) == 0), ($urandom_range(0, 3) == 0),
              ($urandom_range(0, 3) == 0)};
      set_trig(trig);
      op = $urandom_range(0, 9); w = 1'b0; widx = 0; wd = '0;
      if (op < 2) begin
        widx = $urandom_range(0, 6);
        wd   = $urandom;
        if (widx == 0 && $urandom_range(0, 3) != 0) wd[NUM_CH-1:0] = '1;
        w = 1'b1;
        bus_wr_drive(32'(widx) << 2, wd);
      end else if (op == 2) begin
        ridx = $urandom_range(0, 7);
        rd(32'(ridx) << 2, rdat);
        chk("rnd_rd", rdat, m_read(ridx));
      end else begin
        bus_idle();
      end
      m_update(trig, w, widx, wd);
    end
    step();
    chk("rnd_final", {27'd0, intr, outs()}, {27'd0, m_intr(), m_out});

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/tim_etb_route.md
# tim_etb_route

Event-trigger router between the timer pair and the timer trigger-enable inputs. It takes single-cycle trigger pulses from the timers (`tim1_etb_trig`, `tim2_etb_trig`) and an external source. It routes them through APB-configured channels to the `etb_tim1/2_trig_en_on/off` pulse inputs of the timer top. It sits on the same APB segment as the timer, and its four pulse outputs wire straight into the timer block.

## Interface
- `NUM_CH`, 2: number of routing channels (1..4).
- `pclk` input 1: APB/system clock; all logic is in this domain.
- `preset` input 1: asynchronous, active-high reset.
- `psel` input 1: APB select.
- `penable` input 1: APB enable.
- `pwrite` input 1: APB write.
- `paddr` input 32: APB address; bits [4:2] are decoded.
- `pwdata` input 32: APB write data.
- `prdata` output 32: APB read data; zero when not reading.
- `tim1_etb_trig` input 1: timer-1 trigger pulse (source 0).
- `tim2_etb_trig` input 1: timer-2 trigger pulse (source 1).
- `ext_trig` input 1: external trigger pulse, already synchronous to `pclk` (source 2).
- `etb_tim1_trig_en_on` output 1: one-cycle pulse that enables timer 1.
- `etb_tim1_trig_en_off` output 1: one-cycle pulse that disables timer 1.
- `etb_tim2_trig_en_on` output 1: one-cycle pulse that enables timer 2.
- `etb_tim2_trig_en_off` output 1: one-cycle pulse that disables timer 2.
- `intr` output 1: level interrupt, `|(STATUS.fired & CTRL.ie)`.

## Operation
- Registers (zero-wait APB; a write takes effect on the `psel&penable&pwrite` edge; reads are combinational):
  - 0x00 CTRL: [NUM_CH-1:0] `en`, [8+ch] `oneshot`, [16+ch] `ie`.
  - 0x04+4·ch CHn_CFG: [1:0] `src` (0 tim1, 1 tim2, 2 ext, 3 none), [2] `dst` (0 tim1, 1 tim2), [3] `act` (1 on, 0 off).
  - 0x14 STATUS: [ch] `fired`, write-1-to-clear.
  - 0x18 SWTRIG: write-only; writing 1 to bit [ch] injects a trigger on channel ch. Reads return 0.
  - Unmapped reads return 0; unmapped writes are ignored.
- Per-channel FSM:
  - IDLE (`en`=0): `en`=1 -> ARMED.
  - ARMED: a selected-source pulse or an SWTRIG bit -> FIRE.
  - FIRE (1 cycle): drives the decoded dst/act request.
    - If `oneshot` is set, go to DONE and clear `en` in hardware.
    - Otherwise return to ARMED.
  - DONE: software writing `en`=1 -> ARMED.
  - From any state, `en` written to 0 -> IDLE. Any FIRE already in progress completes.
- `fired[ch]` sets in the FIRE cycle. Set has priority over a simultaneous W1C.
- Output merge: each output is the OR of all channel requests targeting it in that cycle.
  - If on and off for the same timer coincide, off wins and on is suppressed.
  - Outputs are registered.
- A source pulse arriving while the channel is in FIRE is accepted: the channel re-enters FIRE on the next cycle in continuous mode. In oneshot mode it is dropped.
- `src`=3 ignores hardware sources; SWTRIG still fires the channel.
- CHn_CFG written while ARMED takes effect for the next detected event.

## Timing
- Reset values: all outputs 0; CTRL, CHn_CFG and STATUS are 0; all FSMs in IDLE.
- Source pulse in cycle N -> channel in FIRE in cycle N+1 -> output pulse high in cycle N+2 for exactly one cycle.
- SWTRIG write in cycle N -> output pulse in cycle N+2.
- Continuous source high for k cycles -> k output pulses on consecutive cycles starting at N+2.
- Write `en`=1 in cycle N: a pulse in cycle N is ignored; a pulse in cycle N+1 is detected.
- Asserting reset mid-FIRE drops pending pulses immediately and asynchronously.

## Configuration
- `TIM_ETB_SWTRIG_EN` defined: the SWTRIG register at 0x18 exists and injects triggers as described above.
- Not defined: offset 0x18 is unmapped, and the software-trigger path and its logic are removed. Hardware routing is unaffected.

## Structure
- Package `tim_etb_pkg` holds:
  - register offsets;
  - `src` encodings (SRC_TIM1, SRC_TIM2, SRC_EXT, SRC_NONE);
  - the channel FSM state enum;
  - the `NUM_CH` maximum.
- Sub-module `tim_etb_chnl` covers one channel: source mux, FSM, and the fired/request outputs. It is instantiated NUM_CH times.
- The top holds the APB register file, the output merge with off-priority, the output registers, and `intr`.

## Test plan
- CH0 cfg src=0, dst=1, act=1; CTRL=0x1. Pulse `tim1_etb_trig` in cycle 10 -> `etb_tim2_trig_en_on`=1 in cycle 12 only; STATUS=0x1.
- CH0 oneshot (CTRL=0x101). Two tim1 pulses 5 cycles apart -> one output pulse only; CTRL reads 0x100.
- CH0 on-tim1 and CH1 off-tim1, both from src=2. One `ext_trig` pulse -> only `etb_tim1_trig_en_off` pulses.
- CTRL ie0=1 (0x10001). Fire CH0 -> `intr`=1. Write STATUS=0x1 -> `intr`=0 on the next cycle.
- With `TIM_ETB_SWTRIG_EN`: write SWTRIG=0x2 with CH1 src=3, dst=0, act=0 -> `etb_tim1_trig_en_off` pulses 2 cycles later.
- Assert reset during FIRE -> all outputs 0 immediately; CTRL and STATUS read 0 after release.
